// File: rtl/sha256_message_padder.sv
// sha256_message_padder
// ---------------------------------------------------------------------------
// This block assembles a big-endian 32-bit byte stream into 512-bit SHA-256
// blocks. On the final word of a message it applies the standard padding:
// a 0x80 terminator byte, zero fill, and the 64-bit big-endian message bit
// length. If the terminator and the length do not both fit in the current
// block, the block is emitted as-is. A second pad-only block then follows.
//
// Ports:
//   clk             rising-edge clock
//   sync_rst        synchronous active-high reset; discards any partial message
//   data_in         message word; the first byte is in [31:24]
//   data_in_keep    byte count of the final word (0..4, values >4 count as 4)
//   data_in_last    final word of the message
//   data_in_valid   input word valid
//   data_in_ready   padder can accept a word (only while collecting)
//   data_out        512-bit block; word k is at [511-32k -: 32]
//   data_out_last   final padded block of the message
//   data_out_valid  block valid
//   data_out_ready  downstream accepts the block
//   msg_len_bits    (only with SHA256_PADDER_LEN_OUT_EN) total message bit
//                   length, updated when the final block becomes pending
//
// Optional feature macro: SHA256_PADDER_LEN_OUT_EN
// ---------------------------------------------------------------------------
module sha256_message_padder #(
    parameter int INWIDTH   = 32,
    parameter int OUTWIDTH  = 512,
    parameter int LENWIDTH  = 64,
    parameter int KEEPWIDTH = $clog2(INWIDTH/8)+1
) (
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic [INWIDTH-1:0]   data_in,
    input  logic [KEEPWIDTH-1:0] data_in_keep,
    input  logic                 data_in_last,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUTWIDTH-1:0]  data_out,
    output logic                 data_out_last,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
`ifdef SHA256_PADDER_LEN_OUT_EN
    ,
    output logic [LENWIDTH-1:0]  msg_len_bits
`endif
);

    localparam int BLK_BYTES = OUTWIDTH/8;
    localparam int LEN_BYTE0 = BLK_BYTES - LENWIDTH/8;

    typedef enum logic [1:0] {COLLECT, EMIT_DATA, EMIT_EXTRA, EMIT_FINAL} state_t;

    state_t                state_reg, state_next;
    logic [OUTWIDTH-1:0]   acc_reg, acc_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [LENWIDTH-4:0]   byte_cnt_reg, byte_cnt_next;
    logic                  pad_done_reg, pad_done_next;

    // Candidate block contents, selected by the FSM.
    logic [OUTWIDTH-1:0]   word_blk;   // accumulator with data_in in slot cnt
    logic [OUTWIDTH-1:0]   last_blk;   // accumulator closed off with padding
    logic [OUTWIDTH-1:0]   pad_blk;    // pad-only follow-up block

    logic [2:0]            keep_clamped;
    logic [6:0]            slot_base;  // byte index of slot cnt
    logic [6:0]            pos;        // byte index right after the last message byte
    logic [LENWIDTH-4:0]   byte_cnt_sum;
    logic [LENWIDTH-1:0]   len_last;   // length including the final word
    logic [LENWIDTH-1:0]   len_cur;    // length already accumulated

    assign keep_clamped = (data_in_keep > KEEPWIDTH'(4)) ? 3'd4 : 3'(data_in_keep);
    assign slot_base    = {1'b0, cnt_reg, 2'b00};
    assign pos          = slot_base + {4'b0000, keep_clamped};
    assign byte_cnt_sum = byte_cnt_reg + (LENWIDTH-3)'(keep_clamped);
    assign len_last     = {byte_cnt_sum, 3'b000};
    assign len_cur      = {byte_cnt_reg, 3'b000};

    generate
        for (genvar gi = 0; gi < BLK_BYTES; gi++) begin : g_byte
            localparam logic [3:0] SLOT = 4'(gi/4);
            localparam logic [6:0] IDX  = 7'(gi);
            localparam int         LANE = gi % 4;

            logic [7:0] acc_byte;
            logic [7:0] in_byte;
            logic [7:0] len_last_byte;
            logic [7:0] len_cur_byte;

            assign acc_byte = acc_reg[OUTWIDTH-1-8*gi -: 8];
            assign in_byte  = data_in[INWIDTH-1-8*LANE -: 8];

            if (gi >= LEN_BYTE0) begin : g_len
                assign len_last_byte = len_last[LENWIDTH-1-8*(gi-LEN_BYTE0) -: 8];
                assign len_cur_byte  = len_cur[LENWIDTH-1-8*(gi-LEN_BYTE0) -: 8];
            end else begin : g_nolen
                assign len_last_byte = 8'h00;
                assign len_cur_byte  = 8'h00;
            end

            assign word_blk[OUTWIDTH-1-8*gi -: 8] = (cnt_reg == SLOT) ? in_byte : acc_byte;

            // Earlier slots keep their data; the bytes up to pos come from the
            // final word; then the terminator; then zeros, or the length when
            // the terminator leaves room for it (pos <= 55).
            assign last_blk[OUTWIDTH-1-8*gi -: 8] =
                (IDX < slot_base)                    ? acc_byte      :
                (IDX < pos)                          ? in_byte       :
                (IDX == pos)                         ? 8'h80         :
                (pos <= 7'(LEN_BYTE0 - 1))           ? len_last_byte :
                                                       8'h00;

            if (gi == 0) begin : g_pad0
                assign pad_blk[OUTWIDTH-1 -: 8] = pad_done_reg ? 8'h00 : 8'h80;
            end else begin : g_padn
                assign pad_blk[OUTWIDTH-1-8*gi -: 8] = len_cur_byte;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg    <= COLLECT;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            byte_cnt_reg <= '0;
            pad_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            pad_done_reg <= pad_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        pad_done_next  = pad_done_reg;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_last  = 1'b0;
        data_out       = acc_reg;

        case (state_reg)
            COLLECT: begin
                data_in_ready = 1'b1;
                if (data_in_valid) begin
                    if (!data_in_last) begin
                        acc_next      = word_blk;
                        cnt_next      = cnt_reg + 4'd1;
                        byte_cnt_next = byte_cnt_reg + (LENWIDTH-3)'(4);
                        if (cnt_reg == 4'd15) begin
                            state_next = EMIT_DATA;
                        end
                    end else begin
                        acc_next      = last_blk;
                        byte_cnt_next = byte_cnt_sum;
                        if (pos < 7'(BLK_BYTES)) begin
                            pad_done_next = 1'b1;
                        end
                        state_next = (pos <= 7'(LEN_BYTE0 - 1)) ? EMIT_FINAL : EMIT_EXTRA;
                    end
                end
            end
            EMIT_DATA: begin
                data_out_valid = 1'b1;
                if (data_out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = COLLECT;
                end
            end
            EMIT_EXTRA: begin
                data_out_valid = 1'b1;
                // The pad block is loaded on the handshake edge so that the
                // final block is valid on the very next cycle.
                if (data_out_ready) begin
                    acc_next   = pad_blk;
                    state_next = EMIT_FINAL;
                end
            end
            EMIT_FINAL: begin
                data_out_valid = 1'b1;
                data_out_last  = 1'b1;
                if (data_out_ready) begin
                    cnt_next      = '0;
                    byte_cnt_next = '0;
                    pad_done_next = 1'b0;
                    state_next    = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

`ifdef SHA256_PADDER_LEN_OUT_EN
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            msg_len_bits <= '0;
        end else if (state_reg == COLLECT && data_in_valid && data_in_last &&
                     pos <= 7'(LEN_BYTE0 - 1)) begin
            msg_len_bits <= len_last;
        end else if (state_reg == EMIT_EXTRA && data_out_ready) begin
            msg_len_bits <= len_cur;
        end
    end
`endif

endmodule
